stage4ma: RTL and testbench

Memory-access stage of the 24-bit pipeline, the consumer of the execute stage's EX/MA latch. It takes the execute result, store data and instruction, runs load/store transactions on a request/ready data-memory port, and stalls upstream while a transaction is outstanding. It presents a registered MA/WB latch to write-back. Non-memory instructions pass through with one cycle of latency.

---
 rtl/stage4ma.sv | 138 +++++++++++++
 tb/tb_stage4ma.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/stage4ma.sv
// stage4ma: memory-access stage; runs load/store on a request/ready port and
// registers the MA/WB latch, stalling EX/MA while a transaction is outstanding.
module stage4ma #(
  parameter int TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable_in,
  input  logic [23:0] pc_in,
  input  logic [23:0] instr_in,
  input  logic [23:0] result_in,
  input  logic [23:0] store_data_in,
  input  logic [3:0]  tgt_gp_in,
  input  logic [3:0]  tgt_sr_in,
  input  logic [3:0]  flags_in,
  input  logic        branch_taken_in,
  output logic        stall_out,
  output logic        mem_req,
  output logic        mem_we,
  output logic [23:0] mem_addr,
  output logic [23:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [23:0] mem_rdata,
  output logic        enable_out,
  output logic [23:0] pc_out,
  output logic [23:0] instr_out,
  output logic [23:0] result_out,
  output logic [3:0]  tgt_gp_out,
  output logic [3:0]  tgt_sr_out,
  output logic [3:0]  flags_out,
  output logic        branch_taken_out,
  output logic        err_out
);
  localparam logic [7:0] OPC_R_LD  = 8'h20;
  localparam logic [7:0] OPC_I_LDi = 8'h21;
  localparam logic [7:0] OPC_R_ST  = 8'h22;
  localparam logic [7:0] OPC_I_STi = 8'h23;
  localparam logic [23:0] TO_LAST = 24'(TIMEOUT - 1);
  typedef enum logic {IDLE, ACCESS} state_t;
  typedef struct packed {
    logic [23:0] pc;
    logic [23:0] instr;
    logic [3:0]  gp;
    logic [3:0]  sr;
    logic [3:0]  flags;
    logic        br;
  } fld_t;
  state_t      state_q, state_d;
  fld_t        fld_in, cap_q, cap_d, out_q, out_d;
  logic [23:0] cnt_q, cnt_d, addr_q, addr_d, wdata_q, wdata_d, result_q, result_d;
  logic        req_q, req_d, we_q, we_d, en_q, en_d, err_q, err_d;
  logic        is_ld, is_st, timeout;
  assign fld_in  = {pc_in, instr_in, tgt_gp_in, tgt_sr_in, flags_in, branch_taken_in};
  assign is_ld   = instr_in[23:16] == OPC_R_LD || instr_in[23:16] == OPC_I_LDi;
  assign is_st   = instr_in[23:16] == OPC_R_ST || instr_in[23:16] == OPC_I_STi;
  // mem_ready has priority, so timeout only fires while still waiting
  assign timeout = TIMEOUT != 0 && state_q == ACCESS && !mem_ready && cnt_q == TO_LAST;
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cap_d    = cap_q;
    out_d    = out_q;
    result_d = result_q;
    err_d    = err_q;
    en_d     = 1'b0;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    if (state_q == IDLE) begin
      if (enable_in && !(is_ld || is_st)) begin
        out_d    = fld_in;
        result_d = result_in;
        err_d    = 1'b0;
        en_d     = 1'b1;
      end else if (enable_in) begin
        cap_d   = fld_in;
        addr_d  = result_in;
        wdata_d = is_st ? store_data_in : '0;
        we_d    = is_st;
        req_d   = 1'b1;
        cnt_d   = '0;
        state_d = ACCESS;
      end
    end else begin
      cnt_d = &cnt_q ? cnt_q : cnt_q + 24'd1;
      if (mem_ready || timeout) begin
        req_d    = 1'b0;
        out_d    = cap_q;
        result_d = mem_ready ? (we_q ? addr_q : mem_rdata) : '0;
        err_d    = !mem_ready;
        en_d     = 1'b1;
        state_d  = IDLE;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      cap_q    <= '0;
      out_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      en_q     <= 1'b0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cap_q    <= cap_d;
      out_q    <= out_d;
      result_q <= result_d;
      err_q    <= err_d;
      en_q     <= en_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end
  assign stall_out        = state_q == ACCESS;
  assign mem_req          = req_q;
  assign mem_we           = we_q;
  assign mem_addr         = addr_q;
  assign mem_wdata        = wdata_q;
  assign enable_out       = en_q;
  assign pc_out           = out_q.pc;
  assign instr_out        = out_q.instr;
  assign result_out       = result_q;
  assign tgt_gp_out       = out_q.gp;
  assign tgt_sr_out       = out_q.sr;
  assign flags_out        = out_q.flags;
  assign branch_taken_out = out_q.br;
  assign err_out          = err_q;
endmodule

// File: tb/tb_stage4ma.sv
// tb_stage4ma: directed bench for stage4ma with a scoreboard of expected MA/WB latches.
module tb_stage4ma;
  localparam logic [7:0] OPC_R_ADD = 8'h01;
  localparam logic [7:0] OPC_I_LDi = 8'h21;
  localparam logic [7:0] OPC_R_ST  = 8'h22;
  logic        clk = 1'b0, rst = 1'b0, enable_in = 1'b0, branch_taken_in = 1'b0, mem_ready = 1'b0;
  logic [23:0] pc_in = '0, instr_in = '0, result_in = '0, store_data_in = '0, mem_rdata = '0;
  logic [3:0]  tgt_gp_in = '0, tgt_sr_in = '0, flags_in = '0;
  logic        stall_out, mem_req, mem_we, enable_out, branch_taken_out, err_out;
  logic [23:0] mem_addr, mem_wdata, pc_out, instr_out, result_out;
  logic [3:0]  tgt_gp_out, tgt_sr_out, flags_out;
  typedef struct {
    logic [23:0] pc, instr, result;
    logic [3:0]  gp, sr, flags;
    logic        br, err;
  } exp_t;
  exp_t sb[$];
  int checks = 0, failures = 0, n;
  always #5 clk = ~clk;
  stage4ma #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .enable_in(enable_in), .pc_in(pc_in), .instr_in(instr_in),
    .result_in(result_in), .store_data_in(store_data_in), .tgt_gp_in(tgt_gp_in),
    .tgt_sr_in(tgt_sr_in), .flags_in(flags_in), .branch_taken_in(branch_taken_in),
    .stall_out(stall_out), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .enable_out(enable_out), .pc_out(pc_out), .instr_out(instr_out), .result_out(result_out),
    .tgt_gp_out(tgt_gp_out), .tgt_sr_out(tgt_sr_out), .flags_out(flags_out),
    .branch_taken_out(branch_taken_out), .err_out(err_out)
  );
  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(negedge clk);
  endtask
  task automatic issue(input logic [7:0] op, input logic [23:0] pc, res, sd, exp_res,
                       input logic [3:0] gp, sr, fl, input logic br, err, push);
    exp_t e;
    enable_in = 1'b1;
    pc_in = pc;
    instr_in = {op, pc[15:0] ^ 16'h5A3C};
    result_in = res;
    store_data_in = sd;
    tgt_gp_in = gp;
    tgt_sr_in = sr;
    flags_in = fl;
    branch_taken_in = br;
    e = '{pc: pc, instr: {op, pc[15:0] ^ 16'h5A3C}, result: exp_res, gp: gp, sr: sr,
          flags: fl, br: br, err: err};
    if (push) sb.push_back(e);
  endtask
  task automatic check_out(input string tag);
    exp_t e;
    chk({tag, ".en"}, 160'(enable_out), 160'(1'b1));
    checks++;
    assert (sb.size() != 0) else begin
      failures++;
      $error("FAIL %s.sb observed=empty expected=entry", tag);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, ".pc"}, 160'(pc_out), 160'(e.pc));
      chk({tag, ".instr"}, 160'(instr_out), 160'(e.instr));
      chk({tag, ".result"}, 160'(result_out), 160'(e.result));
      chk({tag, ".misc"}, 160'({tgt_gp_out, tgt_sr_out, flags_out, branch_taken_out, err_out}),
          160'({e.gp, e.sr, e.flags, e.br, e.err}));
    end
  endtask
  function automatic logic [159:0] all_out();
    return 160'({enable_out, mem_req, mem_we, mem_addr, mem_wdata, pc_out, instr_out, result_out,
                 tgt_gp_out, tgt_sr_out, flags_out, branch_taken_out, err_out, stall_out});
  endfunction
  initial begin
    // reset with random inputs, including a valid memory opcode
    issue(OPC_I_LDi, 24'($urandom), 24'($urandom), 24'($urandom), 24'd0, 4'($urandom),
          4'($urandom), 4'($urandom), 1'b1, 1'b0, 1'b0);
    mem_ready = 1'b1;
    mem_rdata = 24'($urandom);
    step();
    step();
    chk("reset.outputs", all_out(), '0);
    rst = 1'b1;
    enable_in = 1'b0;
    mem_ready = 1'b0;
    step();
    step();
    chk("post_reset.outputs", all_out(), '0);
    // pass-through
    issue(OPC_R_ADD, 24'h000400, 24'h000123, 24'h0, 24'h000123, 4'h3, 4'h5, 4'b0001, 1'b1, 1'b0, 1'b1);
    step();
    enable_in = 1'b0;
    chk("pass.req", 160'({mem_req, stall_out}), 160'(2'b00));
    check_out("pass");
    step();
    chk("pass.bubble", 160'({enable_out, mem_req}), 160'(2'b00));
    // load, mem_ready in the 3rd ACCESS cycle
    issue(OPC_I_LDi, 24'h000404, 24'h00ABCD, 24'h777777, 24'h5A5A5A, 4'h7, 4'h2, 4'b1010, 1'b0, 1'b0, 1'b1);
    step();
    enable_in = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      chk($sformatf("load.req%0d", k), 160'({mem_req, mem_we, stall_out, enable_out}), 160'(4'b1010));
      chk($sformatf("load.bus%0d", k), 160'({mem_addr, mem_wdata}), 160'({24'h00ABCD, 24'h0}));
      if (k == 3) begin
        mem_ready = 1'b1;
        mem_rdata = 24'h5A5A5A;
      end
      step();
    end
    mem_ready = 1'b0;
    check_out("load");
    chk("load.done", 160'({mem_req, stall_out}), 160'(2'b00));
    // store with immediate ready; the next instruction is held on the input meanwhile
    issue(OPC_R_ST, 24'h000408, 24'h000010, 24'hFFFFFE, 24'h000010, 4'h1, 4'h0, 4'b0110, 1'b0, 1'b0, 1'b1);
    step();
    chk("store.bus", 160'({mem_req, mem_we, mem_addr, mem_wdata}), 160'({2'b11, 24'h000010, 24'hFFFFFE}));
    chk("store.stall", 160'(stall_out), 160'(1'b1));
    issue(OPC_R_ADD, 24'h00040C, 24'h00BEEF, 24'h0, 24'h00BEEF, 4'h9, 4'hA, 4'b1100, 1'b1, 1'b0, 1'b1);
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    check_out("store");
    step();
    enable_in = 1'b0;
    check_out("held_add");
    // timeout after exactly 4 ACCESS cycles
    issue(OPC_I_LDi, 24'h000410, 24'h000777, 24'h0, 24'h0, 4'h4, 4'h4, 4'b0011, 1'b0, 1'b1, 1'b1);
    step();
    enable_in = 1'b0;
    n = 0;
    while (stall_out && n < 20) begin
      n++;
      step();
    end
    chk("timeout.cycles", 160'(n), 160'(4));
    check_out("timeout");
    chk("timeout.req", 160'(mem_req), 160'(1'b0));
    issue(OPC_R_ADD, 24'h000414, 24'h000042, 24'h0, 24'h000042, 4'h2, 4'h1, 4'b1000, 1'b0, 1'b0, 1'b1);
    step();
    enable_in = 1'b0;
    check_out("after_timeout");
    // reset in the 2nd ACCESS cycle
    issue(OPC_I_LDi, 24'h000418, 24'h000ABC, 24'h0, 24'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    step();
    enable_in = 1'b0;
    step();
    chk("midrst.stall", 160'({stall_out, mem_req}), 160'(2'b11));
    rst = 1'b0;
    step();
    chk("midrst.drop", 160'({mem_req, stall_out, enable_out}), 160'(3'b000));
    rst = 1'b1;
    mem_ready = 1'b1;
    mem_rdata = 24'h123456;
    step();
    chk("midrst.late_ready", 160'({enable_out, mem_req, stall_out}), 160'(3'b000));
    mem_ready = 1'b0;
    step();
    chk("midrst.idle", 160'({enable_out, result_out}), 160'(0));
    chk("sb.empty", 160'(sb.size()), 160'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
